// File: rtl/uart_bus_device_pkg.sv
// uart_bus_device_pkg: shared widths, default timing and FSM encodings for the UART bus device.
package uart_bus_device_pkg;
  localparam int CLKS_PER_BIT_DEF = 16;
  localparam int DATA_BITS_DEF = 8;
  localparam int BUS_W = 16;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_tx_ser.sv
// uart_tx_ser: transmit holding register plus serialiser; chains frames back-to-back when the holding register is full.
module uart_tx_ser
  import uart_bus_device_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic [7:0] din,
  output logic       txd,
  output logic       tbre,
  output logic       tsre
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  tx_state_t state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_idx;
  logic [7:0] hold;
  logic [DATA_BITS-1:0] shift;
  logic last, last_bit;
  assign last = cnt == CW'(CLKS_PER_BIT - 1);
  assign last_bit = bit_idx == BW'(DATA_BITS - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= TX_IDLE;
      cnt <= '0;
      bit_idx <= '0;
      hold <= '0;
      shift <= '0;
      txd <= 1'b1;
      tbre <= 1'b1;
      tsre <= 1'b1;
    end else begin
      if (wr && tbre) begin
        hold <= din;
        tbre <= 1'b0;
      end
      cnt <= (state == TX_IDLE || last) ? '0 : cnt + 1'b1;
      case (state)
        TX_IDLE: if (!tbre) begin
          shift <= DATA_BITS'(hold);
          tbre <= 1'b1;
          tsre <= 1'b0;
          txd <= 1'b0;
          state <= TX_START;
        end
        TX_START: if (last) begin
          txd <= shift[0];
          bit_idx <= '0;
          state <= TX_DATA;
        end
        TX_DATA: if (last) begin
          shift <= shift >> 1;
          bit_idx <= bit_idx + 1'b1;
          txd <= last_bit ? 1'b1 : shift[1];
          state <= last_bit ? TX_STOP : TX_DATA;
        end
        TX_STOP: if (last) begin
          // a pending byte starts its start bit right after this stop bit
          if (!tbre) begin
            shift <= DATA_BITS'(hold);
            tbre <= 1'b1;
            txd <= 1'b0;
            state <= TX_START;
          end else begin
            tsre <= 1'b1;
            state <= TX_IDLE;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
endmodule

// File: rtl/uart_bus_device.sv
// uart_bus_device: bus-attached UART with strobe edge detection, TX serialiser and inline mid-bit sampling receiver.
module uart_bus_device
  import uart_bus_device_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wrn,
  input  logic             rdn,
  input  logic [BUS_W-1:0] data_in,
  output logic [BUS_W-1:0] data_out,
  output logic             data_oe,
  output logic             data_ready,
  output logic             tbre,
  output logic             tsre,
  output logic             txd,
  input  logic             rxd,
  output logic             overrun,
  output logic             framing_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  logic wrn_q, rdn_q, wr_stb, rd_rise;
  logic [2:0] rx_sync;
  rx_state_t rx_state;
  logic [CW-1:0] rx_cnt;
  logic [BW-1:0] rx_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic [7:0] rx_buf, rd_hold;
  logic rx_bit, rx_last, rx_half, done;
  logic unused_bits;
  assign unused_bits = ^data_in[BUS_W-1:8];
  // a read in progress masks any write edge
  assign wr_stb = wrn_q & ~wrn & rdn;
  assign rd_rise = ~rdn_q & rdn;
  assign rx_bit = rx_sync[1];
  assign rx_last = rx_cnt == CW'(CLKS_PER_BIT - 1);
  assign rx_half = rx_cnt == CW'(CLKS_PER_BIT / 2 - 1);
  assign done = rx_state == RX_STOP && rx_last && rx_bit;
  assign data_oe = ~rdn;
  assign data_out = {{(BUS_W - 8){1'b0}}, rdn_q ? rx_buf : rd_hold};
  uart_tx_ser #(.CLKS_PER_BIT(CLKS_PER_BIT), .DATA_BITS(DATA_BITS)) u_tx (
    .clk(clk), .rst(rst), .wr(wr_stb), .din(data_in[7:0]),
    .txd(txd), .tbre(tbre), .tsre(tsre)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wrn_q <= 1'b1;
      rdn_q <= 1'b1;
      rx_sync <= 3'b111;
      rx_state <= RX_IDLE;
      rx_cnt <= '0;
      rx_idx <= '0;
      rx_shift <= '0;
      rx_buf <= '0;
      rd_hold <= '0;
      data_ready <= 1'b0;
      overrun <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      wrn_q <= wrn;
      rdn_q <= rdn;
      rx_sync <= {rx_sync[1:0], rxd};
      framing_err <= 1'b0;
      // a byte landing on the read-release edge wins over the clear
      data_ready <= done | (data_ready & ~rd_rise);
      overrun <= done ? data_ready & ~rd_rise : overrun & ~rd_rise;
      if (rdn_q) rd_hold <= rx_buf;
      rx_cnt <= (rx_state == RX_IDLE || (rx_state == RX_START ? rx_half : rx_last)) ? '0 : rx_cnt + 1'b1;
      case (rx_state)
        RX_IDLE: if (rx_sync[2] && !rx_sync[1]) rx_state <= RX_START;
        RX_START: if (rx_half) begin
          rx_idx <= '0;
          rx_state <= rx_bit ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (rx_last) begin
          rx_shift <= {rx_bit, rx_shift[DATA_BITS-1:1]};
          rx_idx <= rx_idx + 1'b1;
          if (rx_idx == BW'(DATA_BITS - 1)) rx_state <= RX_STOP;
        end
        RX_STOP: if (rx_last) begin
          rx_state <= RX_IDLE;
          if (rx_bit) rx_buf <= 8'(rx_shift);
          else framing_err <= 1'b1;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_bus_device.sv
// tb_uart_bus_device: directed stimulus with queued expectations checked by independent TX-line and bus-read monitors.
module tb_uart_bus_device;
  localparam int C = 4;
  logic clk = 1'b0, rst = 1'b1, wrn = 1'b1, rdn = 1'b1, rxd = 1'b1;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic data_oe, data_ready, tbre, tsre, txd, overrun, framing_err;
  int tests = 0, fails = 0, fe_cnt = 0;
  logic [7:0] tx_q[$];
  logic [15:0] rx_q[$];

  uart_bus_device #(.CLKS_PER_BIT(C), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .wrn(wrn), .rdn(rdn), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe), .data_ready(data_ready),
    .tbre(tbre), .tsre(tsre), .txd(txd), .rxd(rxd),
    .overrun(overrun), .framing_err(framing_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic do_write(input logic [7:0] d);
    data_in = {8'h00, d};
    wrn = 1'b0;
    @(negedge clk);
    wrn = 1'b1;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [15:0] exp);
    rx_q.push_back(exp);
    rdn = 1'b0;
    @(negedge clk);
    chk("read_oe", data_oe, 1);
    @(negedge clk);
    rdn = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (C) @(negedge clk);
    end
    rxd = stop;
    repeat (C) @(negedge clk);
    rxd = 1'b1;
    repeat (C) @(negedge clk);
  endtask

  task automatic wait_idle(input string n);
    for (int i = 0; i < 200 && !tsre; i++) @(negedge clk);
    chk(n, tsre, 1);
  endtask

  initial forever begin
    @(negedge clk);
    if (framing_err) fe_cnt++;
  end

  initial begin : tx_mon
    logic prev, ok, s0, s9;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && prev && !txd) begin
        ok = 1'b1;
        b = '0;
        s0 = 1'b1;
        s9 = 1'b0;
        for (int k = 0; k < 10 && ok; k++) begin
          for (int j = 0; j < (k == 0 ? 1 : C); j++) begin
            @(negedge clk);
            if (rst) ok = 1'b0;
          end
          if (k == 0) s0 = txd;
          else if (k == 9) s9 = txd;
          else b[k-1] = txd;
        end
        for (int j = 0; j < C - 2 && ok; j++) begin
          @(negedge clk);
          if (rst) ok = 1'b0;
        end
        if (ok) begin
          if (tx_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL tx_extra_frame: got frame %0h expected none", {s9, b, s0});
          end else chk("tx_frame", {s9, b, s0}, {1'b1, tx_q.pop_front(), 1'b0});
        end
      end
      prev = rst | txd;
    end
  end

  initial begin : rx_mon
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (data_oe && !prev) begin
        if (rx_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rx_extra_read: got %0h expected no read", data_out);
        end else chk("rx_read", data_out, rx_q.pop_front());
      end
      prev = data_oe;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_tbre", tbre, 1);
    chk("rst_tsre", tsre, 1);
    chk("rst_ready", data_ready, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_ferr", framing_err, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_oe", data_oe, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    tx_q.push_back(8'h55);
    data_in = 16'h0055;
    wrn = 1'b0;
    @(negedge clk);
    chk("w55_tbre_low", tbre, 0);
    wrn = 1'b1;
    @(negedge clk);
    chk("w55_tbre_high", tbre, 1);
    chk("w55_tsre_low", tsre, 0);
    chk("w55_start", txd, 0);
    wait_idle("w55_tsre");
    repeat (3) @(negedge clk);

    tx_q.push_back(8'hA5);
    do_write(8'hA5);
    chk("b2b_start1", txd, 0);
    tx_q.push_back(8'h3C);
    do_write(8'h3C);
    chk("b2b_hold_full", tbre, 0);
    do_write(8'hFF);
    chk("drop_tbre", tbre, 0);
    repeat (35) @(negedge clk);
    chk("b2b_stop1", txd, 1);
    @(negedge clk);
    chk("b2b_no_gap", txd, 0);
    chk("b2b_tbre", tbre, 1);
    wait_idle("b2b_tsre");
    repeat (3) @(negedge clk);

    send_rx(8'hC3, 1'b1);
    chk("rxC3_ready", data_ready, 1);
    chk("rxC3_overrun", overrun, 0);
    bus_read(16'h00C3);
    chk("rxC3_cleared", data_ready, 0);

    send_rx(8'h11, 1'b1);
    chk("ovr_first_ready", data_ready, 1);
    chk("ovr_first_clean", overrun, 0);
    send_rx(8'hE7, 1'b1);
    chk("ovr_set", overrun, 1);
    bus_read(16'h00E7);
    chk("ovr_ready_clr", data_ready, 0);
    chk("ovr_clr", overrun, 0);

    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_ready", data_ready, 0);
    chk("glitch_ferr", fe_cnt, 0);
    send_rx(8'h5A, 1'b0);
    chk("ferr_pulse", fe_cnt, 1);
    chk("ferr_ready", data_ready, 0);

    rx_q.push_back(16'h00E7);
    data_in = 16'h0077;
    rdn = 1'b0;
    wrn = 1'b0;
    @(negedge clk);
    chk("rdwr_suppress", tbre, 1);
    rdn = 1'b1;
    wrn = 1'b1;
    @(negedge clk);
    chk("rdwr_no_capture", tbre, 1);
    repeat (3) @(negedge clk);

    do_write(8'h00);
    repeat (17) @(negedge clk);
    chk("rst_mid_bit3", txd, 0);
    rst = 1'b1;
    #1;
    chk("rst_mid_txd", txd, 1);
    chk("rst_mid_tbre", tbre, 1);
    chk("rst_mid_tsre", tsre, 1);
    repeat (3) @(negedge clk);
    chk("rst_hold_txd", txd, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tx_q.push_back(8'h96);
    do_write(8'h96);
    wait_idle("post_rst_tsre");

    repeat (20) @(negedge clk);
    chk("tx_q_drained", tx_q.size(), 0);
    chk("rx_q_drained", rx_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
